lane_tx_scheduler: RTL

LANE_TX_SCHEDULER -- requirements
Module: lane_tx_scheduler

---
 rtl/lane_sym_pkg.sv | 44 ++++
 rtl/skp_timer.sv | 42 ++++
 rtl/lane_tx_scheduler.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/lane_sym_pkg.sv
// Shared lane symbol constants, transmit FSM state encoding and the
// arbitration rule. Used by the transmit scheduler and the lane demux.
package lane_sym_pkg;

  // 8b/10b K-code values carried with valid=0
  localparam logic [7:0] SYM_STP = 8'hFB;
  localparam logic [7:0] SYM_SDP = 8'h5C;
  localparam logic [7:0] SYM_END = 8'hFD;
  localparam logic [7:0] SYM_EDB = 8'hFE;
  localparam logic [7:0] SYM_SKP = 8'h1C;
  localparam logic [7:0] SYM_IDL = 8'h7C;
  localparam logic [7:0] SYM_FTS = 8'h3C;
  localparam logic [7:0] SYM_COM = 8'hBC;

  typedef enum logic [3:0] {
    IDLE,
    SKP_COM,
    SKP_SET,
    TLP_STP,
    TLP_DATA,
    DLLP_SDP,
    DLLP_DATA,
    PKT_END,
    PKT_EDB
  } tx_state_e;

  // Ordered sets win over DLLPs, DLLPs win over TLPs; nothing pending -> IDLE.
  function automatic tx_state_e arb_next(input logic i_skp_pending,
                                         input logic i_dllp_req,
                                         input logic i_tlp_req);
    tx_state_e v_next;
    if (i_skp_pending) begin
      v_next = SKP_COM;
    end else if (i_dllp_req) begin
      v_next = DLLP_SDP;
    end else if (i_tlp_req) begin
      v_next = TLP_STP;
    end else begin
      v_next = IDLE;
    end
    return v_next;
  endfunction

endpackage

// File: rtl/skp_timer.sv
// Free-running SKP interval counter with a single-entry pending flag.
// The flag is set on every wrap and cleared by consume; a wrap always wins
// over a simultaneous consume so that set is not lost.
module skp_timer #(
  parameter int SKP_INTERVAL = 1180
) (
  input  logic clk,
  input  logic reset,
  input  logic consume,
  output logic pending
);

  localparam int CNT_W = (SKP_INTERVAL > 1) ? $clog2(SKP_INTERVAL) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SKP_INTERVAL - 1);

  logic [CNT_W-1:0] r_count;
  logic             r_pending;
  logic             w_wrap;

  assign w_wrap  = (r_count == LAST_CNT);
  assign pending = r_pending;

  // Count every cycle regardless of what the lane is sending; raise pending on wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count   <= '0;
      r_pending <= 1'b0;
    end else begin
      if (w_wrap) begin
        r_count <= '0;
      end else begin
        r_count <= r_count + CNT_W'(1);
      end
      if (w_wrap) begin
        r_pending <= 1'b1;
      end else if (consume) begin
        r_pending <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/lane_tx_scheduler.sv
// Lane transmit scheduler: interleaves SKP ordered sets, DLLPs and TLPs onto
// one byte stream for the lane demux. valid_out=1 marks payload bytes,
// valid_out=0 marks control symbols. Packets are never interrupted.
module lane_tx_scheduler
  import lane_sym_pkg::*;
#(
  parameter int SKP_INTERVAL = 1180,
  parameter int SKP_COUNT    = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tlp_req,
  input  logic [7:0] tlp_data,
  input  logic       tlp_last,
  output logic       tlp_ack,
  input  logic       dllp_req,
  input  logic [7:0] dllp_data,
  input  logic       dllp_last,
  output logic       dllp_ack,
  output logic       valid_out,
  output logic [7:0] data_out
);

  localparam int SC_W = (SKP_COUNT > 1) ? $clog2(SKP_COUNT) : 1;
  localparam logic [SC_W-1:0] LAST_SKP = SC_W'(SKP_COUNT - 1);

  tx_state_e       r_state;
  logic [SC_W-1:0] r_skp_idx;
  logic            r_valid_out;
  logic [7:0]      r_data_out;

  logic            w_skp_pending;
  logic            w_skp_consume;
  logic            w_tlp_ack;
  logic            w_dllp_ack;
  tx_state_e       w_arb_state;

  // COM is loaded into data_out on the edge leaving SKP_COM, which is the
  // same edge that drops the pending flag.
  assign w_skp_consume = (r_state == SKP_COM);

  skp_timer #(
    .SKP_INTERVAL(SKP_INTERVAL)
  ) u_skp_timer (
    .clk    (clk),
    .reset  (reset),
    .consume(w_skp_consume),
    .pending(w_skp_pending)
  );

  // Acks are gated by reset so a source never loses a byte to an abort.
  assign w_tlp_ack  = (r_state == TLP_DATA)  && tlp_req  && !reset;
  assign w_dllp_ack = (r_state == DLLP_DATA) && dllp_req && !reset;
  assign w_arb_state = arb_next(w_skp_pending, dllp_req, tlp_req);

  assign tlp_ack   = w_tlp_ack;
  assign dllp_ack  = w_dllp_ack;
  assign valid_out = r_valid_out;
  assign data_out  = r_data_out;

  // Each state loads the symbol it owns into the output register on exit;
  // IDLE, PKT_END, PKT_EDB and the last SKP pick the next sequence.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_skp_idx   <= '0;
      r_valid_out <= 1'b0;
      r_data_out  <= SYM_IDL;
    end else begin
      case (r_state)
        IDLE: begin
          r_valid_out <= 1'b0;
          r_data_out  <= SYM_IDL;
          r_state     <= w_arb_state;
        end
        SKP_COM: begin
          r_valid_out <= 1'b0;
          r_data_out  <= SYM_COM;
          r_skp_idx   <= '0;
          r_state     <= SKP_SET;
        end
        SKP_SET: begin
          r_valid_out <= 1'b0;
          r_data_out  <= SYM_SKP;
          if (r_skp_idx == LAST_SKP) begin
            r_skp_idx <= '0;
            r_state   <= w_arb_state;
          end else begin
            r_skp_idx <= r_skp_idx + SC_W'(1);
          end
        end
        TLP_STP: begin
          r_valid_out <= 1'b0;
          r_data_out  <= SYM_STP;
          r_state     <= TLP_DATA;
        end
        TLP_DATA: begin
          if (w_tlp_ack) begin
            r_valid_out <= 1'b1;
            r_data_out  <= tlp_data;
            if (tlp_last) begin
              r_state <= PKT_END;
            end
          end else begin
            // Source underrun: mark the packet bad right after its last good byte.
            r_valid_out <= 1'b0;
            r_data_out  <= SYM_EDB;
            r_state     <= PKT_EDB;
          end
        end
        DLLP_SDP: begin
          r_valid_out <= 1'b0;
          r_data_out  <= SYM_SDP;
          r_state     <= DLLP_DATA;
        end
        DLLP_DATA: begin
          if (w_dllp_ack) begin
            r_valid_out <= 1'b1;
            r_data_out  <= dllp_data;
            if (dllp_last) begin
              r_state <= PKT_END;
            end
          end else begin
            r_valid_out <= 1'b0;
            r_data_out  <= SYM_EDB;
            r_state     <= PKT_EDB;
          end
        end
        PKT_END: begin
          r_valid_out <= 1'b0;
          r_data_out  <= SYM_END;
          r_state     <= w_arb_state;
        end
        PKT_EDB: begin
          // EDB already went out on entry; fill this slot with IDL.
          r_valid_out <= 1'b0;
          r_data_out  <= SYM_IDL;
          r_state     <= w_arb_state;
        end
        default: begin
          r_valid_out <= 1'b0;
          r_data_out  <= SYM_IDL;
          r_state     <= IDLE;
        end
      endcase
    end
  end

endmodule
